motion_indicator_gen2: RTL and testbench
========================================

MOTION_INDICATOR_GEN2 -- requirements
Module: motion_indicator_gen2

Interface
REQ-001 Parameters: CLK_HZ, default 100_000_000, input clock frequency; SLOW_HZ, default 5, 1x spin step rate; FAST_HZ, default 10, 2x spin step rate; BLINK_HZ, default 2, forward/reverse toggle rate; SIM, default 0, 1 selects short simulation dividers.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 motion_mode  in  3  0 STOP, 1 RIGHT_1x, 2 RIGHT_2x, 3 LEFT_1x, 4 LEFT_2x, 5 FORWARD, 6 REVERSE, 7 FAULT.
REQ-006 enable  in  1  1 = run; 0 = freeze state and all divider counters.
REQ-007 LED  out  5  digit code: A=16, B=17, C=18, D=19, E=20, F=21, G=22, BLANK=23.
REQ-008 seg_onehot  out  8  one-hot state: bit0=a … bit6=g, bit7=blank.
REQ-009 mode_change  out  1  one-cycle pulse when a new mode is accepted.

Function
REQ-010 Divider counts are DIV_x = CLK_HZ/x_HZ; with SIM=1 they are DIV_SLOW=4, DIV_FAST=2, DIV_BLINK=8.
REQ-011 Each divider counts 0..DIV-1 while enable=1 and asserts its tick for one cycle when the count equals DIV-1, then wraps to 0.
REQ-012 State machine states are S_A..S_G and S_BLANK, one-hot encoded; LED and seg_onehot decode combinationally from the state register only.
REQ-013 mode_q holds the last accepted mode plus a valid flag; a mode is accepted on any enabled edge where motion_mode differs from mode_q or valid=0.
REQ-014 On acceptance at edge k: mode_change=1 during cycle k+1 only, all dividers clear to 0, and the state loads its entry value at edge k.
REQ-015 Entry values: STOP→S_G; RIGHT_x→S_A; LEFT_x→S_F; FORWARD→S_A; REVERSE→S_D.
REQ-016 STOP: the state remains S_G.
REQ-017 RIGHT: on each tick, the state advances A→B→C→D→E→F→A; 1x uses the slow tick, 2x the fast tick.
REQ-018 LEFT: on each tick, the state steps F→E→D→C→B→A→F; 1x uses the slow tick, 2x the fast tick.
REQ-019 FORWARD: on each blink tick, the state toggles between S_A and S_BLANK; REVERSE toggles between S_D and S_BLANK.
REQ-020 First advance occurs exactly DIV cycles after entry.
REQ-021 When mode acceptance and a tick coincide, acceptance wins and the tick is discarded.
REQ-022 enable=0: state, mode_q, and counters hold, mode_change=0, and motion_mode changes are ignored until enable=1.
REQ-023 An illegal or non-one-hot state recovers to S_BLANK on the next edge.

Reset
REQ-024 On reset: state=S_BLANK, LED=23, seg_onehot=8'h80, mode_change=0, all counters=0, mode_q valid=0.
REQ-025 Reset has priority over enable and mode acceptance; the first enabled edge after reset always accepts the current mode.
REQ-026 Reset asserted mid-spin or mid-blink takes effect at the next edge with no residual tick.

Configuration
REQ-027 Macro MOTION_IND_FAULT_BLINK_EN: when defined, FAULT (7) enters S_G and toggles S_G/S_BLANK on the fast tick.
REQ-028 Without MOTION_IND_FAULT_BLINK_EN, FAULT behaves exactly as STOP, including entry, but is still a distinct mode for acceptance and mode_change.

Verification (SIM=1)
REQ-029 Reset 3 cycles, mode=STOP, enable=1 -> LED=23 during reset; one edge later LED=22, mode_change pulse=1 cycle.
REQ-030 mode=RIGHT_1x -> LED=16, then 17, 18, 19, 20, 21, 16 at 4-cycle intervals.
REQ-031 mode=LEFT_2x -> LED=21, then 20, 19 at 2-cycle intervals; switch to REVERSE mid-step -> LED=19 next edge, then 23 and 19 alternating every 8 cycles.
REQ-032 FORWARD running, enable=0 for 20 cycles while mode changes to STOP -> LED and counters frozen; after enable=1, STOP is accepted and LED=22.
REQ-033 mode=7 -> with the macro, LED alternates 22/23 every 2 cycles; without it, LED holds 22; mode_change pulses in both builds.
REQ-034 Force an illegal state via the bench -> LED=23 one edge later.

Source files
------------

// File: rtl/motion_indicator_gen2.sv
// -----------------------------------------------------------------------------
// motion_indicator_gen2
// Drives a seven-segment style motion indicator. A one-hot state machine walks
// the outer segments clockwise or anticlockwise (RIGHT/LEFT, 1x or 2x rate),
// blinks a single segment (FORWARD on a, REVERSE on d) or parks on g (STOP).
//
// Optional build feature (macro MOTION_IND_FAULT_BLINK_EN):
//   defined   : FAULT enters g and toggles g/blank on the fast tick
//   undefined : FAULT behaves like STOP but is still a distinct mode
//
// Ports
//   clk          in   1  system clock, rising edge
//   reset        in   1  synchronous active-high reset
//   motion_mode  in   3  requested mode (0 STOP .. 7 FAULT)
//   enable       in   1  1 = run, 0 = freeze state, mode and dividers
//   LED          out  5  digit code A=16 .. G=22, BLANK=23
//   seg_onehot   out  8  one-hot state, bit0=a .. bit6=g, bit7=blank
//   mode_change  out  1  one-cycle pulse after a new mode is accepted
// -----------------------------------------------------------------------------
module motion_indicator_gen2 #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SLOW_HZ  = 5,
    parameter int FAST_HZ  = 10,
    parameter int BLINK_HZ = 2,
    parameter int SIM      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] motion_mode,
    input  logic       enable,
    output logic [4:0] LED,
    output logic [7:0] seg_onehot,
    output logic       mode_change
);

    localparam int DIV_SLOW  = (SIM != 0) ? 4 : CLK_HZ / SLOW_HZ;
    localparam int DIV_FAST  = (SIM != 0) ? 2 : CLK_HZ / FAST_HZ;
    localparam int DIV_BLINK = (SIM != 0) ? 8 : CLK_HZ / BLINK_HZ;

    localparam logic [31:0] SLOW_LAST  = 32'(DIV_SLOW - 1);
    localparam logic [31:0] FAST_LAST  = 32'(DIV_FAST - 1);
    localparam logic [31:0] BLINK_LAST = 32'(DIV_BLINK - 1);

    localparam logic [2:0] M_STOP  = 3'd0;
    localparam logic [2:0] M_R1    = 3'd1;
    localparam logic [2:0] M_R2    = 3'd2;
    localparam logic [2:0] M_L1    = 3'd3;
    localparam logic [2:0] M_L2    = 3'd4;
    localparam logic [2:0] M_FWD   = 3'd5;
    localparam logic [2:0] M_REV   = 3'd6;
    localparam logic [2:0] M_FAULT = 3'd7;

    typedef enum logic [7:0] {
        S_A     = 8'h01,
        S_B     = 8'h02,
        S_C     = 8'h04,
        S_D     = 8'h08,
        S_E     = 8'h10,
        S_F     = 8'h20,
        S_G     = 8'h40,
        S_BLANK = 8'h80
    } state_t;

    // State is kept as a raw vector so corrupted (non-one-hot) values are
    // representable and can be detected and recovered.
    logic [7:0]  state_q, state_d, state_next_s;
    logic [2:0]  mode_q, mode_d;
    logic        valid_q, valid_d;
    logic        mode_change_q, mode_change_d;
    logic [31:0] slow_cnt_q, slow_cnt_d;
    logic [31:0] fast_cnt_q, fast_cnt_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        slow_tick_s, fast_tick_s, blink_tick_s;
    logic        accept_s, legal_s;

    function automatic logic is_legal(input logic [7:0] s);
        logic ok;
        case (s)
            S_A, S_B, S_C, S_D, S_E, S_F, S_G, S_BLANK: ok = 1'b1;
            default:                                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] entry_state(input logic [2:0] m);
        logic [7:0] s;
        case (m)
            M_STOP:      s = S_G;
            M_R1, M_R2:  s = S_A;
            M_L1, M_L2:  s = S_F;
            M_FWD:       s = S_A;
            M_REV:       s = S_D;
            M_FAULT:     s = S_G;
            default:     s = S_BLANK;
        endcase
        return s;
    endfunction

    // Clockwise walk; anything off the ring restarts at a.
    function automatic logic [7:0] right_next(input logic [7:0] s);
        logic [7:0] n;
        case (s)
            S_A:     n = S_B;
            S_B:     n = S_C;
            S_C:     n = S_D;
            S_D:     n = S_E;
            S_E:     n = S_F;
            S_F:     n = S_A;
            default: n = S_A;
        endcase
        return n;
    endfunction

    // Anticlockwise walk; anything off the ring restarts at f.
    function automatic logic [7:0] left_next(input logic [7:0] s);
        logic [7:0] n;
        case (s)
            S_F:     n = S_E;
            S_E:     n = S_D;
            S_D:     n = S_C;
            S_C:     n = S_B;
            S_B:     n = S_A;
            S_A:     n = S_F;
            default: n = S_F;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] toggle(input logic [7:0] s, input logic [7:0] lit);
        logic [7:0] n;
        if (s == lit) begin
            n = S_BLANK;
        end else begin
            n = lit;
        end
        return n;
    endfunction

    function automatic logic [7:0] run_step(input logic [2:0] m, input logic [7:0] s,
                                            input logic slow, input logic fast,
                                            input logic blink);
        logic [7:0] n;
        case (m)
            M_STOP:  n = S_G;
            M_R1:    n = slow  ? right_next(s) : s;
            M_R2:    n = fast  ? right_next(s) : s;
            M_L1:    n = slow  ? left_next(s)  : s;
            M_L2:    n = fast  ? left_next(s)  : s;
            M_FWD:   n = blink ? toggle(s, S_A) : s;
            M_REV:   n = blink ? toggle(s, S_D) : s;
`ifdef MOTION_IND_FAULT_BLINK_EN
            M_FAULT: n = fast  ? toggle(s, S_G) : s;
`else
            M_FAULT: n = S_G;
`endif
            default: n = S_BLANK;
        endcase
        return n;
    endfunction

    assign slow_tick_s  = enable && (slow_cnt_q  == SLOW_LAST);
    assign fast_tick_s  = enable && (fast_cnt_q  == FAST_LAST);
    assign blink_tick_s = enable && (blink_cnt_q == BLINK_LAST);
    assign accept_s     = enable && (!valid_q || (motion_mode != mode_q));
    assign legal_s      = is_legal(state_q);

    // Next-state for mode register, dividers and the state machine.
    always_comb begin
        slow_cnt_d    = slow_cnt_q;
        fast_cnt_d    = fast_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        mode_d        = mode_q;
        valid_d       = valid_q;
        mode_change_d = 1'b0;
        state_next_s  = state_q;
        if (enable) begin
            if (accept_s) begin
                // Acceptance overrides any tick landing on the same edge.
                slow_cnt_d    = 32'd0;
                fast_cnt_d    = 32'd0;
                blink_cnt_d   = 32'd0;
                mode_d        = motion_mode;
                valid_d       = 1'b1;
                mode_change_d = 1'b1;
                state_next_s  = entry_state(motion_mode);
            end else begin
                slow_cnt_d   = slow_tick_s  ? 32'd0 : slow_cnt_q  + 32'd1;
                fast_cnt_d   = fast_tick_s  ? 32'd0 : fast_cnt_q  + 32'd1;
                blink_cnt_d  = blink_tick_s ? 32'd0 : blink_cnt_q + 32'd1;
                state_next_s = run_step(mode_q, state_q, slow_tick_s, fast_tick_s,
                                        blink_tick_s);
            end
        end else begin
            state_next_s = state_q;
        end
        if (legal_s) begin
            state_d = state_next_s;
        end else begin
            state_d = S_BLANK;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_BLANK;
            mode_q        <= M_STOP;
            valid_q       <= 1'b0;
            mode_change_q <= 1'b0;
            slow_cnt_q    <= 32'd0;
            fast_cnt_q    <= 32'd0;
            blink_cnt_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            valid_q       <= valid_d;
            mode_change_q <= mode_change_d;
            slow_cnt_q    <= slow_cnt_d;
            fast_cnt_q    <= fast_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
        end
    end

    // Digit code decoded from the state register alone.
    always_comb begin
        case (state_q)
            S_A:     LED = 5'd16;
            S_B:     LED = 5'd17;
            S_C:     LED = 5'd18;
            S_D:     LED = 5'd19;
            S_E:     LED = 5'd20;
            S_F:     LED = 5'd21;
            S_G:     LED = 5'd22;
            default: LED = 5'd23;
        endcase
    end

    assign seg_onehot  = state_q;
    assign mode_change = mode_change_q;

endmodule

// File: tb/tb_motion_indicator_gen2.sv
// -----------------------------------------------------------------------------
// tb_motion_indicator_gen2
// Directed bench for motion_indicator_gen2 with SIM=1 dividers
// (slow=4, fast=2, blink=8). Inputs change and outputs are sampled on the
// falling edge; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_motion_indicator_gen2;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] motion_mode;
    logic       enable;
    logic [4:0] LED;
    logic [7:0] seg_onehot;
    logic       mode_change;

    int checks = 0;
    int errors = 0;

    motion_indicator_gen2 #(.SIM(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .motion_mode (motion_mode),
        .enable      (enable),
        .LED         (LED),
        .seg_onehot  (seg_onehot),
        .mode_change (mode_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    int right_seq [5] = '{18, 19, 20, 21, 16};

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        motion_mode = 3'd0;

        // Reset state
        step(3);
        check("rst_led", 32'(LED), 32'd23);
        check("rst_seg", 32'(seg_onehot), 32'h80);
        check("rst_mc", 32'(mode_change), 32'd0);
        reset = 1'b0;

        // First enabled edge accepts STOP
        step(1);
        check("stop_led", 32'(LED), 32'd22);
        check("stop_seg", 32'(seg_onehot), 32'h40);
        check("stop_mc", 32'(mode_change), 32'd1);
        step(1);
        check("stop_mc_drop", 32'(mode_change), 32'd0);
        check("stop_hold", 32'(LED), 32'd22);

        // RIGHT_1x walks every 4 cycles
        motion_mode = 3'd1;
        step(1);
        check("r1_entry", 32'(LED), 32'd16);
        check("r1_entry_seg", 32'(seg_onehot), 32'h01);
        check("r1_mc", 32'(mode_change), 32'd1);
        step(3);
        check("r1_before_tick", 32'(LED), 32'd16);
        step(1);
        check("r1_first", 32'(LED), 32'd17);
        for (int i = 0; i < 5; i++) begin
            step(4);
            check("r1_walk", 32'(LED), 32'(right_seq[i]));
        end

        // LEFT_2x every 2 cycles, then REVERSE on a coinciding fast tick
        motion_mode = 3'd4;
        step(1);
        check("l2_entry", 32'(LED), 32'd21);
        step(2);
        check("l2_step1", 32'(LED), 32'd20);
        step(2);
        check("l2_step2", 32'(LED), 32'd19);
        step(1);
        motion_mode = 3'd6;
        step(1);
        check("rev_entry", 32'(LED), 32'd19);
        check("rev_mc", 32'(mode_change), 32'd1);
        step(7);
        check("rev_before_blink", 32'(LED), 32'd19);
        step(1);
        check("rev_blank", 32'(LED), 32'd23);
        step(8);
        check("rev_back", 32'(LED), 32'd19);

        // FORWARD with a freeze that must hold the blink counter
        motion_mode = 3'd5;
        step(1);
        check("fwd_entry", 32'(LED), 32'd16);
        step(3);
        enable = 1'b0;
        step(10);
        check("fwd_frozen", 32'(LED), 32'd16);
        enable = 1'b1;
        step(4);
        check("fwd_resume_hold", 32'(LED), 32'd16);
        step(1);
        check("fwd_blank", 32'(LED), 32'd23);

        // Freeze while the mode changes to STOP
        enable      = 1'b0;
        motion_mode = 3'd0;
        step(20);
        check("frz_led", 32'(LED), 32'd23);
        check("frz_mc", 32'(mode_change), 32'd0);
        enable = 1'b1;
        step(1);
        check("frz_accept_led", 32'(LED), 32'd22);
        check("frz_accept_mc", 32'(mode_change), 32'd1);

        // FAULT mode
        motion_mode = 3'd7;
        step(1);
        check("fault_entry", 32'(LED), 32'd22);
        check("fault_mc", 32'(mode_change), 32'd1);
        step(2);
`ifdef MOTION_IND_FAULT_BLINK_EN
        check("fault_t1", 32'(LED), 32'd23);
        step(2);
        check("fault_t2", 32'(LED), 32'd22);
`else
        check("fault_t1", 32'(LED), 32'd22);
        step(2);
        check("fault_t2", 32'(LED), 32'd22);
`endif

        // Corrupt the state register and watch it recover
        force dut.state_q = 8'h03;
        #1;
        release dut.state_q;
        step(1);
        check("illegal_led", 32'(LED), 32'd23);
        check("illegal_seg", 32'(seg_onehot), 32'h80);

        // Reset mid-spin with a tick pending
        motion_mode = 3'd1;
        step(1);
        check("r1b_entry", 32'(LED), 32'd16);
        step(3);
        reset = 1'b1;
        step(1);
        check("midrst_led", 32'(LED), 32'd23);
        check("midrst_mc", 32'(mode_change), 32'd0);
        reset = 1'b0;
        step(1);
        check("post_rst_led", 32'(LED), 32'd16);
        check("post_rst_mc", 32'(mode_change), 32'd1);
        step(3);
        check("post_rst_hold", 32'(LED), 32'd16);
        step(1);
        check("post_rst_step", 32'(LED), 32'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
